// File: rtl/lutram_test_pkg.sv
// Shared types and elaboration helpers for the LUTRAM readback scanner.
package lutram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam int SETTLE_MAX = 15;

    function automatic int words_per_byte(input int data_w);
        return 8 / data_w;
    endfunction

    function automatic bit params_legal(input int addr_w, input int data_w, input int settle);
        int bits;
        if (addr_w < 1 || addr_w > 16) return 1'b0;
        if (!(data_w inside {1, 2, 4, 8})) return 1'b0;
        if (settle < 1 || settle > SETTLE_MAX) return 1'b0;
        bits = (1 << addr_w) * data_w;
        return (bits >= 8) && (bits % 8 == 0);
    endfunction

endpackage

// File: rtl/lutram_byte_packer.sv
// Packs DATA_W-bit words LSB-first into one byte; lower fill slots hold earlier words.
module lutram_byte_packer
    import lutram_test_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic [7:0]        byte_q,
    output logic              word_last,
    output logic              full
);
    localparam int WPB = words_per_byte(DATA_W);

    logic [3:0] fill;
    logic [2:0] base;

    assign base      = 3'(int'(fill) * DATA_W);
    assign word_last = (fill == 4'(WPB - 1));
    assign full      = (fill == 4'(WPB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= '0;
            fill   <= '0;
        end else if (clear) begin
            byte_q <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            byte_q[base +: DATA_W] <= din;
            fill                   <= fill + 4'd1;
        end
    end

endmodule

// File: rtl/lutram_readback_scanner.sv
// Sweeps a LUTRAM, checks each word against EXP_INIT and streams the packed content
// as bytes over a valid/ready handshake, keeping a mismatch count and first bad address.
module lutram_readback_scanner
    import lutram_test_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 1,
    parameter int SETTLE = 1,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] EXP_INIT = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   mismatch_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic [ADDR_W:0]   CNT_MAX     = (ADDR_W + 1)'(2**ADDR_W);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

    if (!params_legal(ADDR_W, DATA_W, SETTLE)) begin : g_illegal_params
        $error("lutram_readback_scanner: illegal ADDR_W/DATA_W/SETTLE combination");
    end

    state_e            state, state_nxt;
    logic [3:0]        settle_cnt;
    logic              start_ok, handshake, miss;
    logic [DATA_W-1:0] exp_word;
    logic [7:0]        byte_q;
    logic              word_last, full;

    assign start_ok  = start_i && (state == ST_IDLE || state == ST_DONE);
    assign handshake = (state == ST_SEND) && tx_valid_o && tx_ready_i;
    assign exp_word  = EXP_INIT[int'(raddr_o) * DATA_W +: DATA_W];
    assign miss      = (rdata_i != exp_word);

    lutram_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (start_ok || handshake),
        .shift_en  (state == ST_CAPTURE),
        .din       (rdata_i),
        .byte_q    (byte_q),
        .word_last (word_last),
        .full      (full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start_i) state_nxt = ST_SETTLE;
            ST_SETTLE:        if (settle_cnt == SETTLE_LAST) state_nxt = ST_CAPTURE;
            ST_CAPTURE:       state_nxt = word_last ? ST_SEND : ST_SETTLE;
            ST_SEND:          if (handshake) state_nxt = (raddr_o == LAST_ADDR) ? ST_DONE : ST_SETTLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            ST_SETTLE, ST_CAPTURE, ST_SEND: busy_o = 1'b1;
            ST_DONE:                        done_o = 1'b1;
            default: ;
        endcase
    end

    // The byte is presented on the cycle after the packer reports full, then held until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            settle_cnt       <= '0;
            raddr_o          <= '0;
            tx_data_o        <= '0;
            tx_valid_o       <= 1'b0;
            mismatch_cnt_o   <= '0;
            first_err_addr_o <= '0;
        end else begin
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
            if (start_ok) begin
                raddr_o          <= '0;
                mismatch_cnt_o   <= '0;
                first_err_addr_o <= '0;
            end
            if (state == ST_CAPTURE) begin
                if (miss) begin
                    if (mismatch_cnt_o == '0) first_err_addr_o <= raddr_o;
                    if (mismatch_cnt_o != CNT_MAX) mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
                end
                if (!word_last) raddr_o <= raddr_o + 1'b1;
            end
            if (state == ST_SEND) begin
                if (full && !tx_valid_o) begin
                    tx_data_o  <= byte_q;
                    tx_valid_o <= 1'b1;
                end else if (handshake) begin
                    tx_valid_o <= 1'b0;
                    if (raddr_o != LAST_ADDR) raddr_o <= raddr_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lutram_readback_scanner.sv
// Randomized bench for lutram_readback_scanner: two configurations against a byte-image reference model.
module tb_lutram_readback_scanner;

    localparam logic [31:0]  EXP_A = 32'h76543210;
    localparam logic [127:0] EXP_B = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Configuration A: 32 x 1 bit, SETTLE=1
    logic        start_a    = 1'b0;
    logic        tx_ready_a = 1'b0;
    logic [4:0]  raddr_a;
    logic        rdata_a;
    logic [7:0]  tx_data_a;
    logic        tx_valid_a, busy_a, done_a;
    logic [5:0]  mcnt_a;
    logic [4:0]  ferr_a;
    logic [31:0] mem_a = EXP_A;
    assign rdata_a = mem_a[raddr_a];

    lutram_readback_scanner #(.ADDR_W(5), .DATA_W(1), .SETTLE(1), .EXP_INIT(EXP_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .raddr_o(raddr_a), .rdata_i(rdata_a),
        .tx_data_o(tx_data_a), .tx_valid_o(tx_valid_a), .tx_ready_i(tx_ready_a),
        .busy_o(busy_a), .done_o(done_a), .mismatch_cnt_o(mcnt_a), .first_err_addr_o(ferr_a)
    );

    // Configuration B: 64 x 2 bit, SETTLE=3
    logic         start_b    = 1'b0;
    logic         tx_ready_b = 1'b0;
    logic [5:0]   raddr_b;
    logic [1:0]   rdata_b;
    logic [7:0]   tx_data_b;
    logic         tx_valid_b, busy_b, done_b;
    logic [6:0]   mcnt_b;
    logic [5:0]   ferr_b;
    logic [127:0] mem_b = EXP_B;
    assign rdata_b = mem_b[raddr_b*2 +: 2];

    lutram_readback_scanner #(.ADDR_W(6), .DATA_W(2), .SETTLE(3), .EXP_INIT(EXP_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .raddr_o(raddr_b), .rdata_i(rdata_b),
        .tx_data_o(tx_data_b), .tx_valid_o(tx_valid_b), .tx_ready_i(tx_ready_b),
        .busy_o(busy_b), .done_o(done_b), .mismatch_cnt_o(mcnt_b), .first_err_addr_o(ferr_b)
    );

    // Downstream sinks: random ready on the falling edge, record every accepted byte.
    int         pct_a = 100, pct_b = 100;
    logic [7:0] got_a[$], got_b[$];

    always @(negedge clk) begin
        tx_ready_a = ($urandom_range(99) < pct_a);
        if (tx_valid_a && tx_ready_a) got_a.push_back(tx_data_a);
        tx_ready_b = ($urandom_range(99) < pct_b);
        if (tx_valid_b && tx_ready_b) got_b.push_back(tx_data_b);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the dump is the memory image cut into bytes; mismatches compare word by word.
    task automatic model_mism(input logic [127:0] img, input logic [127:0] exp, input int depth,
                              input int dw, output int cnt, output int first);
        logic [127:0] mask;
        mask  = (128'd1 << dw) - 128'd1;
        cnt   = 0;
        first = 0;
        for (int a = 0; a < depth; a++) begin
            if (((img >> (a*dw)) & mask) != ((exp >> (a*dw)) & mask)) begin
                if (cnt == 0) first = a;
                cnt++;
            end
        end
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] q[$], input logic [127:0] img,
                              input int n);
        chk({tag, "_nbytes"}, 64'(q.size()), 64'(n));
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_byte%0d", tag, k), (k < q.size()) ? 64'(q[k]) : 64'hBAD,
                64'(img[8*k +: 8]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int budget);
        for (int i = 0; i < budget && !done_a; i++) tick();
        chk("done_a_wait", 64'(done_a), 64'd1);
    endtask

    task automatic wait_valid_a(input int budget);
        for (int i = 0; i < budget && !tx_valid_a; i++) tick();
        chk("valid_a_wait", 64'(tx_valid_a), 64'd1);
    endtask

    task automatic wait_done_b(input int budget);
        for (int i = 0; i < budget && !done_b; i++) tick();
        chk("done_b_wait", 64'(done_b), 64'd1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic scan_a(input string tag, input logic [31:0] img, input int pct);
        int cnt, first;
        mem_a = img;
        pct_a = pct;
        got_a.delete();
        pulse_start_a();
        wait_done_a(4000);
        chk_stream(tag, got_a, {96'd0, img}, 4);
        model_mism({96'd0, img}, {96'd0, EXP_A}, 32, 1, cnt, first);
        chk({tag, "_mcnt"}, 64'(mcnt_a), 64'(cnt));
        if (cnt != 0) chk({tag, "_ferr"}, 64'(ferr_a), 64'(first));
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
    endtask

    task automatic scan_b(input string tag, input logic [127:0] img, input int pct);
        int cnt, first;
        mem_b = img;
        pct_b = pct;
        got_b.delete();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_done_b(6000);
        chk_stream(tag, got_b, img, 16);
        model_mism(img, EXP_B, 64, 2, cnt, first);
        chk({tag, "_mcnt"}, 64'(mcnt_b), 64'(cnt));
        if (cnt != 0) chk({tag, "_ferr"}, 64'(ferr_b), 64'(first));
    endtask

    initial begin
        int lat;
        logic [31:0]  img_a;
        logic [127:0] img_b;

        #23;
        chk("rst_raddr_a", 64'(raddr_a), 64'd0);
        chk("rst_txdata_a", 64'(tx_data_a), 64'd0);
        chk("rst_valid_a", 64'(tx_valid_a), 64'd0);
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_done_a", 64'(done_a), 64'd0);
        chk("rst_mcnt_a", 64'(mcnt_a), 64'd0);
        chk("rst_ferr_a", 64'(ferr_a), 64'd0);
        chk("rst_valid_b", 64'(tx_valid_b), 64'd0);
        chk("rst_busy_b", 64'(busy_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        scan_a("a_clean", EXP_A, 100);
        chk("a_clean_b0", 64'(got_a[0]), 64'h10);
        chk("a_clean_b3", 64'(got_a[3]), 64'h76);
        scan_a("a_flip9", EXP_A ^ 32'h0000_0200, 100);
        chk("a_flip9_b1", 64'(got_a[1]), 64'h30);
        chk("a_flip9_ferr9", 64'(ferr_a), 64'd9);
        scan_a("a_allbad", ~EXP_A, 100);
        for (int it = 0; it < 6; it++) begin
            img_a = EXP_A ^ ($urandom & $urandom & $urandom);
            scan_a($sformatf("a_rand%0d", it), img_a, 30 + $urandom_range(70));
        end

        // Backpressure on the first byte
        mem_a = EXP_A;
        pct_a = 0;
        got_a.delete();
        pulse_start_a();
        wait_valid_a(100);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold%0d_valid", i), 64'(tx_valid_a), 64'd1);
            chk($sformatf("hold%0d_data", i), 64'(tx_data_a), 64'h10);
            chk($sformatf("hold%0d_raddr", i), 64'(raddr_a), 64'd7);
            tick();
        end
        pct_a = 100;
        wait_done_a(2000);
        chk_stream("a_hold", got_a, {96'd0, EXP_A}, 4);

        // start during SEND is ignored; start in DONE restarts
        pct_a = 0;
        got_a.delete();
        pulse_start_a();
        wait_valid_a(100);
        pulse_start_a();
        pct_a = 100;
        wait_done_a(2000);
        repeat (40) tick();
        chk("ign_done", 64'(done_a), 64'd1);
        chk_stream("ign", got_a, {96'd0, EXP_A}, 4);
        got_a.delete();
        pulse_start_a();
        chk("restart_done", 64'(done_a), 64'd0);
        chk("restart_busy", 64'(busy_a), 64'd1);
        wait_done_a(2000);
        chk_stream("restart", got_a, {96'd0, EXP_A}, 4);

        // Configuration B: first-byte latency then full stream
        mem_b = EXP_B;
        pct_b = 100;
        got_b.delete();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 0;
        for (int i = 0; i < 100 && !tx_valid_b; i++) begin
            tick();
            lat++;
        end
        chk("b_latency", 64'(lat), 64'd17);
        wait_done_b(3000);
        chk_stream("b_clean", got_b, EXP_B, 16);
        chk("b_clean_mcnt", 64'(mcnt_b), 64'd0);
        for (int it = 0; it < 3; it++) begin
            img_b = EXP_B ^ {$urandom & $urandom, $urandom & $urandom,
                             $urandom & $urandom, $urandom & $urandom};
            scan_b($sformatf("b_rand%0d", it), img_b, 40 + $urandom_range(60));
        end

        // Reset while the second byte is waiting
        mem_a = EXP_A;
        pct_a = 100;
        got_a.delete();
        pulse_start_a();
        for (int i = 0; i < 200 && got_a.size() < 1; i++) tick();
        pct_a = 0;
        wait_valid_a(200);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(tx_valid_a), 64'd0);
        chk("arst_txdata", 64'(tx_data_a), 64'd0);
        chk("arst_raddr", 64'(raddr_a), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_done", 64'(done_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pct_a = 100;
        lat = 0;
        repeat (50) begin
            tick();
            if (tx_valid_a) lat++;
        end
        chk("post_rst_valid_cycles", 64'(lat), 64'd0);
        chk("post_rst_bytes", 64'(got_a.size()), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
